// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_reader_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} rd_state_e;

  localparam int SKID_DEPTH = 3;

  function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
    return (ptr == 2'(SKID_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Three-entry circular skid buffer that absorbs the FIFO read latency
// and presents the held words as a valid/ready stream.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [FIFO_WIDTH-1:0] push_data,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic [1:0]            occ
);

  logic [FIFO_WIDTH-1:0] mem [SKID_DEPTH];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic                  pop;

  assign m_valid = rst_n && (occ != 2'd0);
  assign m_data  = rst_n ? mem[rd_ptr] : '0;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      // Simultaneous push and pop leave the fill level untouched
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fifo_reader.sv
// Read-side consumer: issues FIFO reads while there is skid space and
// streams the returned words downstream with valid/ready handshaking.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  empty,
  input  logic                  almostempty,
  input  logic                  underflow,
  input  logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [31:0]           rd_count,
  output logic                  err_underflow
);

  rd_state_e  state;
  rd_state_e  next_state;
  logic       inflight;
  logic [1:0] occ;
  logic [2:0] pending;
  logic       pop;
  logic       unused_status;

  assign unused_status = almostempty;

  fifo_reader_skid #(.FIFO_WIDTH(FIFO_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (data_out),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .occ       (occ)
  );

  // Words already held plus the one still on its way must leave room
  assign pending = {1'b0, occ} + {2'b00, inflight};
  assign rd_en   = rst_n && (state == ACTIVE) && !empty && (pending < 3'(SKID_DEPTH));
  assign pop     = m_valid && m_ready;
  assign busy    = rst_n && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      inflight      <= 1'b0;
      rd_count      <= 32'd0;
      err_underflow <= 1'b0;
    end else begin
      state    <= next_state;
      inflight <= rd_en;
      if (pop)       rd_count      <= rd_count + 32'd1;
      if (underflow) err_underflow <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (en) next_state = ACTIVE;
      ACTIVE: if (!en) next_state = DRAIN;
      DRAIN: begin
        if (en) begin
          next_state = ACTIVE;
        // Leave once nothing is held or in flight, or the last word pops now
        end else if (!inflight && ((occ == 2'd0) || (occ == 2'd1 && pop))) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench: plays the FIFO and compares the stream against a
// word-count/queue model of the reader.
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        empty = 1'b1;
  logic        almostempty = 1'b1;
  logic        underflow = 1'b0;
  logic [15:0] data_out = 16'd0;
  logic        rd_en;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        busy;
  logic [31:0] rd_count;
  logic        err_underflow;

  logic [15:0] fifoQ[$];
  logic [15:0] expQ[$];
  int          held = 0;
  bit          inflightM = 1'b0;
  int          beatTotal = 0;
  int          phase = 0;
  bit          errM = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          rdEnPulses, beatsSeen, firstRd, firstValid, firstBeat, lastBeat;

  fifo_reader #(.FIFO_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .empty         (empty),
    .almostempty   (almostempty),
    .underflow     (underflow),
    .data_out      (data_out),
    .rd_en         (rd_en),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .busy          (busy),
    .rd_count      (rd_count),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  task automatic resetStats();
    rdEnPulses = 0;
    beatsSeen  = 0;
    firstRd    = -1;
    firstValid = -1;
    firstBeat  = -1;
    lastBeat   = -1;
  endtask

  // One clock cycle: compare at the falling edge, advance model at the rising edge
  task automatic applyStimulus();
    bit rdS;
    bit expRd;
    bit beatM;
    empty       = (fifoQ.size() == 0);
    almostempty = (fifoQ.size() <= 2);
    @(negedge clk);
    rdS   = rd_en;
    beatM = (held != 0) && m_ready;
    if (!rst_n) begin
      checkOutput("rst_rd_en", rd_en, 0);
      checkOutput("rst_m_valid", m_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_m_data", m_data, 0);
      rdS = 1'b0;
    end else begin
      expRd = (phase == 1) && !empty && (held + int'(inflightM) < 3);
      checkOutput("rd_en", rdS, expRd);
      checkOutput("m_valid", m_valid, held != 0);
      if (held != 0) checkOutput("m_data", m_data, expQ[0]);
      checkOutput("busy", busy, phase != 0);
      checkOutput("rd_count", rd_count, beatTotal);
      checkOutput("err_underflow", err_underflow, errM);
      if (rdS) begin
        rdEnPulses++;
        if (firstRd < 0) firstRd = cycle;
      end
      if (m_valid && firstValid < 0) firstValid = cycle;
      if (m_valid && m_ready) begin
        beatsSeen++;
        if (firstBeat < 0) firstBeat = cycle;
        lastBeat = cycle;
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      held = 0;
      expQ.delete();
      beatTotal = 0;
      phase = 0;
      errM = 1'b0;
    end else begin
      if (beatM) begin
        void'(expQ.pop_front());
        held--;
        beatTotal++;
      end
      if (inflightM) begin
        expQ.push_back(data_out);
        held++;
      end
      if (underflow) errM = 1'b1;
      case (phase)
        0: if (en) phase = 1;
        1: if (!en) phase = 2;
        default: if (en) phase = 1; else if (held == 0) phase = 0;
      endcase
    end
    inflightM = rdS;
    #1;
    cycle++;
    if (rdS && fifoQ.size() > 0) data_out = fifoQ.pop_front();
    else data_out = 16'($urandom);
  endtask

  task automatic waitHeldTwoInflight(input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      applyStimulus();
      if (held == 2 && inflightM) found = 1'b1;
    end
    checkOutput(tag, found, 1);
  endtask

  initial begin
    resetStats();
    repeat (3) applyStimulus();
    rst_n = 1'b1;
    applyStimulus();

    // Streaming at full rate
    for (int i = 1; i <= 16; i++) fifoQ.push_back(16'(i));
    resetStats();
    m_ready = 1'b1;
    en = 1'b1;
    repeat (24) applyStimulus();
    checkOutput("stream_latency", firstValid - firstRd, 2);
    checkOutput("stream_beats", beatsSeen, 16);
    checkOutput("stream_no_bubble", lastBeat - firstBeat, 15);
    checkOutput("stream_count", rd_count, 16);
    en = 1'b0;
    repeat (4) applyStimulus();

    // Backpressure fills the skid buffer, then releases
    for (int i = 0; i < 8; i++) fifoQ.push_back(16'h0100 + 16'(i));
    resetStats();
    m_ready = 1'b0;
    en = 1'b1;
    repeat (10) applyStimulus();
    checkOutput("bp_rd_pulses", rdEnPulses, 3);
    checkOutput("bp_hold_data", m_data, 16'h0100);
    m_ready = 1'b1;
    repeat (15) applyStimulus();
    checkOutput("bp_total_beats", beatsSeen, 8);
    en = 1'b0;
    repeat (4) applyStimulus();

    // Alternating ready
    for (int i = 0; i < 20; i++) fifoQ.push_back(16'h0200 + 16'(i));
    resetStats();
    en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      m_ready = ~m_ready;
      applyStimulus();
    end
    checkOutput("alt_beats", beatsSeen, 20);
    en = 1'b0;
    m_ready = 1'b1;
    repeat (4) applyStimulus();

    // Drain with two held and one in flight
    for (int i = 0; i < 10; i++) fifoQ.push_back(16'h0300 + 16'(i));
    m_ready = 1'b0;
    en = 1'b1;
    waitHeldTwoInflight("drain_setup");
    resetStats();
    en = 1'b0;
    m_ready = 1'b1;
    repeat (6) applyStimulus();
    checkOutput("drain_rd_pulses", rdEnPulses, 0);
    checkOutput("drain_beats", beatsSeen, 3);
    checkOutput("drain_idle", busy, 0);

    // Sticky underflow flag, cleared only by reset
    underflow = 1'b1;
    applyStimulus();
    underflow = 1'b0;
    repeat (3) applyStimulus();
    checkOutput("err_sticky", err_underflow, 1);
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("err_cleared", err_underflow, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) != 0);
      m_ready = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 2) == 0 && fifoQ.size() < 16) fifoQ.push_back(16'($urandom));
      applyStimulus();
    end

    // Reset in the middle of a stream
    for (int i = 0; i < 6; i++) fifoQ.push_back(16'h0400 + 16'(i));
    en = 1'b1;
    m_ready = 1'b0;
    waitHeldTwoInflight("rstmid_setup");
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    m_ready = 1'b1;
    applyStimulus();
    checkOutput("rstmid_count", rd_count, 0);
    checkOutput("rstmid_valid", m_valid, 0);
    repeat (20) applyStimulus();
    en = 1'b0;
    repeat (5) applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Read-side consumer for the synchronous FIFO. It turns the FIFO's `rd_en`/`data_out`/`empty` read port into a valid/ready stream for downstream logic. It absorbs the FIFO's one-cycle read latency with a 3-entry skid buffer, so the stream runs at full throughput under arbitrary backpressure without losing data. It never reads an empty FIFO.

## Interface
- `FIFO_WIDTH`, 16, data word width; must match the FIFO.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `en`  input  1  run request; 1 = fetch from FIFO, 0 = stop fetching and drain what is held.
- `empty`  input  1  FIFO empty flag.
- `almostempty`  input  1  FIFO almost-empty flag; status only, does not gate reads.
- `underflow`  input  1  FIFO underflow flag.
- `data_out`  input  FIFO_WIDTH  FIFO read data; valid in the cycle after an accepted `rd_en`.
- `rd_en`  output  1  FIFO read strobe.
- `m_data`  output  FIFO_WIDTH  stream data, taken from the head of the skid buffer.
- `m_valid`  output  1  stream valid.
- `m_ready`  input  1  stream ready.
- `busy`  output  1  1 whenever the state is not IDLE.
- `rd_count`  output  32  number of beats accepted on the stream (`m_valid && m_ready`); wraps at 2^32.
- `err_underflow`  output  1  sticky; set if `underflow` is ever 1.

## Operation
- Skid buffer:
  - 3 entries, circular, with `wr_ptr`/`rd_ptr` (2 bits each, wrap at 3) and `occ` (0..3).
  - `inflight` = registered copy of last cycle's `rd_en`.
- Read issue is combinational: `rd_en = rst_n && run && !empty && (occ + inflight) < 3`.
  - `run` is 1 only in state ACTIVE.
  - `rd_en` never depends on `m_ready`.
- Capture: when `inflight` = 1, `data_out` is written at `wr_ptr` at the end of that cycle.
- Pop: when `m_valid && m_ready`, `rd_ptr` advances and `rd_count` increments.
- Push and pop in the same cycle: `occ` is unchanged and both pointers advance.
- `m_valid = (occ != 0)`; `m_data` = the entry at `rd_ptr`.
- `m_data` must hold stable while `m_valid && !m_ready`.
- State machine (states IDLE, ACTIVE, DRAIN):
  - IDLE → ACTIVE when `en` = 1.
  - ACTIVE → DRAIN when `en` = 0.
  - DRAIN → ACTIVE when `en` = 1.
  - DRAIN → IDLE when `occ == 0 && inflight == 0`, or when `occ` would become 0 this cycle because the last entry pops.
  - In DRAIN: no new `rd_en`; the in-flight word is still captured, and held words are still offered on the stream.
- `err_underflow` is cleared only by reset. Under correct operation it is never set, because `rd_en` is never asserted while `empty` = 1.

## Timing
- Reset (`rst_n` = 0 at a rising edge):
  - State → IDLE; `occ`, pointers, `inflight`, `rd_count`, `err_underflow` → 0.
  - Outputs while `rst_n` = 0: `rd_en` = 0, `m_valid` = 0, `busy` = 0, `m_data` = 0.
  - Reset mid-operation discards held and in-flight words. A `data_out` arriving in the cycle after reset is ignored.
- Latency: `rd_en` = 1 in cycle t → word captured at the t+1/t+2 edge → `m_valid` = 1 in cycle t+2.
- `en` rising in cycle t → ACTIVE at t+1 → first `rd_en` in t+1 if `!empty`.
- Steady state with `m_ready` = 1: `occ` = 1 and `inflight` = 1, giving one `rd_en` and one pop every cycle (100% throughput).
- Backpressure: `rd_en` drops once `occ + inflight` = 3. At most 3 words are held; no overflow of the skid buffer is possible.
- `empty` rising: `rd_en` drops in the same cycle. The held and in-flight words still drain.

## Structure
- Package `fifo_reader_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} rd_state_e;`
  - `localparam SKID_DEPTH = 3;`
- Sub-module `fifo_reader_skid` holds the pointers, `occ`, storage, push/pop logic and the `m_data`/`m_valid` drive.
- The top level holds the FSM, `inflight`, the `rd_en` equation, `rd_count` and `err_underflow`.

## Test plan
- **Reset mid-stream:** reset while `occ` = 2 and `inflight` = 1 → next cycle `m_valid` = 0, `rd_count` = 0, `rd_en` = 0; the stale `data_out` is not emitted.
- **Streaming:** preload FIFO with 0x0001..0x0010, `en` = 1, `m_ready` = 1 → first `m_valid` 2 cycles after the first `rd_en`; 16 consecutive beats in order with no bubbles; `rd_count` = 16; `rd_en` never high while `empty` = 1.
- **Backpressure:** FIFO holds 8 words, `m_ready` = 0 → exactly 3 `rd_en` pulses, then `occ` = 3 with `m_data` stable at the first word. Release `m_ready` → remaining words follow in order, none lost or duplicated.
- **Alternating ready:** `m_ready` toggles every cycle over 20 words → 20 beats in order; `occ` never exceeds 3; `err_underflow` stays 0.
- **Drain:** `en` drops with `occ` = 2 and `inflight` = 1 → no further `rd_en`; 3 more beats are emitted; IDLE on the cycle after the last pop; `busy` = 0.
- **Underflow flag:** force `underflow` = 1 for one cycle → `err_underflow` = 1 and stays 1 until `rst_n` = 0.
